// File: rtl/store_monitor_pkg.sv
// Shared types for the store monitor: verdict states and the trace entry layout.
package store_mon_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } mon_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } trace_entry_t;
endpackage

// File: rtl/store_monitor_sync_fifo.sv
// Generic synchronous FIFO: registered head, pointers wrap modulo DEPTH, occupancy kept separately.
// A push at full is accepted only when a pop frees a slot in the same cycle; flush empties it.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/store_monitor.sv
// Traces core stores into a FIFO and keeps a RUN/PASS/FAIL verdict on the store stream.
// STORE_MON_TIMEOUT_EN adds a watchdog that forces FAIL after TIMEOUT_CYC cycles in RUN.
module store_monitor
  import store_mon_pkg::*;
#(
  parameter int                DEPTH       = 8,
  parameter logic [ADDR_W-1:0] PASS_ADDR   = 32'd100,
  parameter logic [DATA_W-1:0] PASS_DATA   = 32'd25,
  parameter logic [ADDR_W-1:0] WIN_LO      = 32'd0,
  parameter logic [ADDR_W-1:0] WIN_HI      = 32'd255,
  parameter int unsigned       TIMEOUT_CYC = 10000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemWrite,
  input  logic [ADDR_W-1:0]      DataAddr,
  input  logic [DATA_W-1:0]      WriteData,
  input  logic                   clear,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [ADDR_W-1:0]      trace_addr,
  output logic [DATA_W-1:0]      trace_data,
  output logic [$clog2(DEPTH):0] trace_count,
  output logic                   overflow,
  output logic                   done,
  output logic                   pass,
  output logic                   fail,
  output logic                   timeout
);
  mon_state_e   state_q, state_d;
  logic         overflow_q, overflow_d;
  logic         push, fifo_full, fifo_empty, in_win;
  trace_entry_t wr_entry, head;

  assign push     = MemWrite & ~clear;
  assign wr_entry = '{addr: DataAddr, data: WriteData};
  // Single unsigned compare covers both window bounds, and stays sane when WIN_LO is 0.
  assign in_win   = (DataAddr - WIN_LO) <= (WIN_HI - WIN_LO);

  sync_fifo #(.DEPTH(DEPTH), .W($bits(trace_entry_t))) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (clear),
    .push  (push),
    .pop   (trace_ready),
    .wdata (wr_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (trace_count)
  );

  assign trace_valid = ~fifo_empty;
  assign trace_addr  = trace_valid ? head.addr : '0;
  assign trace_data  = trace_valid ? head.data : '0;
  assign overflow    = overflow_q;
  assign done        = (state_q != ST_RUN);
  assign pass        = (state_q == ST_PASS);
  assign fail        = (state_q == ST_FAIL);

`ifdef STORE_MON_TIMEOUT_EN
  logic [31:0] cyc_q, cyc_d;
  logic        timeout_q, timeout_d;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q | (push & fifo_full & ~trace_ready);
`ifdef STORE_MON_TIMEOUT_EN
    cyc_d     = cyc_q;
    timeout_d = timeout_q;
`endif
    if (clear) begin
      state_d    = ST_RUN;
      overflow_d = 1'b0;
`ifdef STORE_MON_TIMEOUT_EN
      cyc_d     = '0;
      timeout_d = 1'b0;
`endif
    end else if (state_q == ST_RUN) begin
      if (MemWrite) begin
        if (DataAddr == PASS_ADDR)
          state_d = (WriteData == PASS_DATA) ? ST_PASS : ST_FAIL;
        else if (!in_win)
          state_d = ST_FAIL;
      end
`ifdef STORE_MON_TIMEOUT_EN
      cyc_d = cyc_q + 32'd1;
      // A terminal store on the expiry cycle decides the verdict instead of the watchdog.
      if (state_d == ST_RUN && cyc_q == 32'(TIMEOUT_CYC - 1)) begin
        state_d   = ST_FAIL;
        timeout_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      overflow_q <= 1'b0;
`ifdef STORE_MON_TIMEOUT_EN
      cyc_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
`ifdef STORE_MON_TIMEOUT_EN
      cyc_q     <= cyc_d;
      timeout_q <= timeout_d;
`endif
    end
  end
endmodule

// File: tb/tb_store_monitor.sv
// Bench for store_monitor: directed scenarios plus random traffic against a queue-based model.
module tb_store_monitor;
  localparam int DEPTH  = 8;
  localparam int TO_CYC = 50;
`ifdef STORE_MON_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int V_RUN = 0, V_PASS = 1, V_FAIL = 2;

  logic        clk = 1'b0;
  logic        reset, MemWrite, clear, trace_ready;
  logic [31:0] DataAddr, WriteData;
  logic        trace_valid, overflow, done, pass, fail, timeout;
  logic [31:0] trace_addr, trace_data;
  logic [3:0]  trace_count;

  store_monitor #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAddr(DataAddr), .WriteData(WriteData),
    .clear(clear), .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_addr(trace_addr),
    .trace_data(trace_data), .trace_count(trace_count), .overflow(overflow), .done(done),
    .pass(pass), .fail(fail), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] mq[$];
  bit          m_ovf, m_to;
  int          m_verdict, m_run;

  function automatic void model_reset();
    mq.delete();
    m_ovf = 0; m_to = 0; m_verdict = V_RUN; m_run = 0;
  endfunction

  function automatic void model_edge(bit mw, logic [31:0] a, logic [31:0] d, bit clr, bit rdy);
    bit was_run;
    if (clr) begin
      model_reset();
      return;
    end
    was_run = (m_verdict == V_RUN);
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    if (mw) begin
      if (mq.size() < DEPTH) mq.push_back({a, d});
      else m_ovf = 1;
    end
    if (was_run && mw) begin
      if (a == 32'd100) m_verdict = (d == 32'd25) ? V_PASS : V_FAIL;
      else if (a > 32'd255) m_verdict = V_FAIL;
    end
    if (TO_EN && was_run && m_verdict == V_RUN && m_run == TO_CYC - 1) begin
      m_verdict = V_FAIL;
      m_to = 1;
    end
    if (was_run) m_run++;
  endfunction

  function automatic logic [9:0] exp_status();
    return {mq.size() != 0, 4'(mq.size()), m_ovf, m_verdict != V_RUN,
            m_verdict == V_PASS, m_verdict == V_FAIL, m_to};
  endfunction

  function automatic logic [9:0] dut_status();
    return {trace_valid, trace_count, overflow, done, pass, fail, timeout};
  endfunction

  task automatic step(bit mw, logic [31:0] a, logic [31:0] d, bit clr, bit rdy);
    MemWrite = mw; DataAddr = a; WriteData = d; clear = clr; trace_ready = rdy;
    @(posedge clk);
    model_edge(mw, a, d, clr, rdy);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; MemWrite = 1'b0; DataAddr = 32'd100; WriteData = 32'd25;
    clear = 1'b0; trace_ready = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      #4;
      MemWrite = ~MemWrite;
      n_checks++;
      if ({dut_status(), trace_addr, trace_data} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got status=%b addr=%0d data=%0d, required all zero",
                 dut_status(), trace_addr, trace_data);
      end
    end
    #1 MemWrite = 1'b0;
    #1 reset = 1'b1;
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (trace_count !== 4'd0 || trace_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got count=%0d valid=%b, required 0/0", trace_count, trace_valid);
    end
  endtask

  task automatic test_pass_drain();
    step(0, 0, 0, 1, 0);
    step(1, 96, 7, 0, 1);
    n_checks++;
    if ({trace_addr, trace_data, trace_count} !== {32'd96, 32'd7, 4'd1}) begin
      n_fail++;
      $display("FAIL first_entry: got (%0d,%0d) count=%0d, required (96,7) count=1",
               trace_addr, trace_data, trace_count);
    end
    step(1, 100, 25, 0, 1);
    n_checks++;
    if ({trace_addr, trace_data, pass, done, fail} !== {32'd100, 32'd25, 3'b110}) begin
      n_fail++;
      $display("FAIL pass_verdict: got (%0d,%0d) pass=%b done=%b fail=%b, required (100,25) 1 1 0",
               trace_addr, trace_data, pass, done, fail);
    end
    step(0, 0, 0, 0, 1);
    n_checks++;
    if (dut_status() !== exp_status() || trace_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_drained: got status=%b, required %b", dut_status(), exp_status());
    end
  endtask

  task automatic test_fail_freeze();
    step(0, 0, 0, 1, 0);
    step(1, 100, 24, 0, 0);
    n_checks++;
    if ({fail, pass} !== 2'b10) begin
      n_fail++;
      $display("FAIL bad_data_verdict: got fail=%b pass=%b, required 1 0", fail, pass);
    end
    step(1, 100, 25, 0, 0);
    n_checks++;
    if ({fail, pass, trace_count, trace_addr, trace_data} !== {2'b10, 4'd2, 32'd100, 32'd24}) begin
      n_fail++;
      $display("FAIL frozen_verdict: got fail=%b pass=%b count=%0d head=(%0d,%0d), required 1 0 2 (100,24)",
               fail, pass, trace_count, trace_addr, trace_data);
    end
    step(0, 0, 0, 0, 1);
    n_checks++;
    if ({trace_valid, trace_addr, trace_data} !== {1'b1, 32'd100, 32'd25}) begin
      n_fail++;
      $display("FAIL late_store_traced: got valid=%b (%0d,%0d), required 1 (100,25)",
               trace_valid, trace_addr, trace_data);
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_window();
    step(0, 0, 0, 1, 0);
    step(1, 255, 9, 0, 1);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL window_edge: got done=%b, required 0", done);
    end
    step(1, 300, 5, 0, 1);
    n_checks++;
    if ({fail, done} !== 2'b11) begin
      n_fail++;
      $display("FAIL out_of_window: got fail=%b done=%b, required 1 1", fail, done);
    end
    step(0, 0, 0, 1, 0);
    n_checks++;
    if ({done, trace_valid, trace_count} !== {2'b00, 4'd0}) begin
      n_fail++;
      $display("FAIL clear_flush: got done=%b valid=%b count=%0d, required 0 0 0", done, trace_valid, trace_count);
    end
    step(1, 100, 25, 1, 0);
    n_checks++;
    if ({done, trace_count} !== {1'b0, 4'd0} || dut_status() !== exp_status()) begin
      n_fail++;
      $display("FAIL clear_beats_store: got done=%b count=%0d, required 0 0", done, trace_count);
    end
  endtask

  task automatic test_overflow();
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      step(1, 96, i + 1, 0, 0);
      if (i >= 7) begin
        n_checks++;
        if ({trace_count, overflow} !== {4'd8, (i == 8)}) begin
          n_fail++;
          $display("FAIL fill_%0d: got count=%0d overflow=%b, required 8 %b", i, trace_count, overflow, i == 8);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({trace_valid, trace_data} !== {1'b1, 32'(i + 1)}) begin
        n_fail++;
        $display("FAIL drain_%0d: got valid=%b data=%0d, required 1 %0d", i, trace_valid, trace_data, i + 1);
      end
      step(0, 0, 0, 0, 1);
    end
    n_checks++;
    if (trace_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ninth_dropped: got valid=%b, required 0", trace_valid);
    end
    for (int i = 0; i < 8; i++) step(1, 96, 20 + i, 0, 0);
    step(1, 96, 99, 0, 1);
    n_checks++;
    if ({trace_count, trace_data} !== {4'd8, 32'd21} || dut_status() !== exp_status()) begin
      n_fail++;
      $display("FAIL push_pop_full: got count=%0d head=%0d, required 8 21", trace_count, trace_data);
    end
  endtask

  task automatic test_random();
    step(0, 0, 0, 1, 0);
    for (int n = 0; n < 400; n++) begin
      bit          clr, mw, rdy;
      logic [31:0] a, d;
      int          r;
      clr = ($urandom_range(0, 19) == 0);
      mw  = $urandom_range(0, 1);
      rdy = ($urandom_range(0, 2) != 0);
      r   = $urandom_range(0, 15);
      if (r == 0) a = 32'd100;
      else if (r == 1) a = 32'd256 + $urandom_range(0, 99);
      else begin
        a = $urandom_range(0, 255);
        if (a == 32'd100) a = 32'd101;
      end
      d = $urandom_range(0, 1) ? 32'd25 : $urandom_range(0, 49);
      step(mw, a, d, clr, rdy);
      n_checks++;
      if (dut_status() !== exp_status()) begin
        n_fail++;
        $display("FAIL random_status[%0d]: got %b, required %b", n, dut_status(), exp_status());
      end
      if (mq.size() != 0) begin
        n_checks++;
        if ({trace_addr, trace_data} !== mq[0]) begin
          n_fail++;
          $display("FAIL random_head[%0d]: got %h, required %h", n, {trace_addr, trace_data}, mq[0]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 96, i, 0, 0);
    #3 reset = 1'b0;
    #1;
    n_checks++;
    if ({trace_valid, trace_count} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_mid_drain: got valid=%b count=%0d, required 0 0", trace_valid, trace_count);
    end
    model_reset();
    #1 reset = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      step(0, 0, 0, 0, 0);
      n_checks++;
      if (dut_status() !== exp_status()) begin
        n_fail++;
        $display("FAIL idle_status[%0d]: got %b, required %b", i, dut_status(), exp_status());
      end
      if (i == 49) begin
        n_checks++;
        if (fail !== 1'b0) begin
          n_fail++;
          $display("FAIL early_timeout: got fail=%b at cycle 49, required 0", fail);
        end
      end
    end
    n_checks++;
    if ({fail, timeout} !== {TO_EN, TO_EN}) begin
      n_fail++;
      $display("FAIL watchdog_expiry: got fail=%b timeout=%b, required %b %b", fail, timeout, TO_EN, TO_EN);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL time_limit: simulation still running at %0t", $time);
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_pass_drain();
    test_fail_freeze();
    test_window();
    test_overflow();
    test_random();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
